// File: rtl/bbc_kbd_pkg.sv
// bbc_kbd_pkg: shared sizes, IRQ row mask and key-index mapping for the BBC keyboard matrix.
package bbc_kbd_pkg;
  localparam int NUM_ROWS = 8;
  localparam int MAX_COLS = 10;
  localparam int COL_W = 4;
  localparam int ROW_W = 3;
  localparam int NUM_KEYS = NUM_ROWS * MAX_COLS;
  localparam logic [NUM_ROWS-1:0] IRQ_ROW_MASK = 8'hFE;
  function automatic logic [6:0] key_index(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return 7'(row) * 7'(MAX_COLS) + 7'(col);
  endfunction
endpackage

// File: rtl/bbc_key_matrix.sv
// bbc_key_matrix: 80-bit key store with event write, bulk clear and a column read port.
module bbc_key_matrix
  import bbc_kbd_pkg::*;
#(
  parameter int NUM_COLS = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_wr_en,
  input  logic                i_wr_data,
  input  logic [ROW_W-1:0]    i_wr_row,
  input  logic [COL_W-1:0]    i_wr_col,
  input  logic [COL_W-1:0]    i_rd_col,
  output logic [NUM_ROWS-1:0] o_rd_rows
);
  logic [NUM_KEYS-1:0] r_keys;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_keys <= '0;
    else if (i_clear) r_keys <= '0;
    else if (i_wr_en && int'(i_wr_col) < NUM_COLS) r_keys[key_index(i_wr_row, i_wr_col)] <= i_wr_data;
  // Unpopulated columns read as empty so they never alias into the next row.
  always_comb begin
    o_rd_rows = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      o_rd_rows[r] = (int'(i_rd_col) < NUM_COLS) && r_keys[key_index(ROW_W'(r), i_rd_col)];
  end
endmodule

// File: rtl/bbc_keyboard_scan.sv
// bbc_keyboard_scan: BBC keyboard matrix emulation driving VIA CA2 (key interrupt) and PA7 (key sense).
module bbc_keyboard_scan
  import bbc_kbd_pkg::*;
#(
  parameter int         NUM_COLS  = 10,
  parameter logic [7:0] DIP_LINKS = 8'h00
) (
  input  logic             PHI_2,
  input  logic             nRESET,
  input  logic             nKBEN,
  input  logic [6:0]       PA_IN,
  input  logic             KEY_VALID,
  input  logic             KEY_DOWN,
  input  logic [ROW_W-1:0] KEY_ROW,
  input  logic [COL_W-1:0] KEY_COL,
  input  logic             KEY_CLEAR,
  output logic             CA2,
  output logic             PA7,
  output logic [COL_W-1:0] SCAN_COL
);
  logic [COL_W-1:0]    r_col;
  logic                r_ca2;
  logic [NUM_ROWS-1:0] w_rows;
  logic [2:0]          w_dip_sel;
  logic                w_dip;
  bbc_key_matrix #(.NUM_COLS(NUM_COLS)) u_matrix (
    .i_clk     (PHI_2),
    .i_rst_n   (nRESET),
    .i_clear   (KEY_CLEAR),
    .i_wr_en   (KEY_VALID),
    .i_wr_data (KEY_DOWN),
    .i_wr_row  (KEY_ROW),
    .i_wr_col  (KEY_COL),
    .i_rd_col  (r_col),
    .o_rd_rows (w_rows)
  );
  always_ff @(posedge PHI_2 or negedge nRESET)
    if (!nRESET) begin
      r_col <= '0;
      r_ca2 <= 1'b0;
    end else begin
      r_col <= nKBEN ? PA_IN[3:0] : r_col + 4'd1;
      r_ca2 <= |(w_rows & IRQ_ROW_MASK);
    end
  // DIP links sit on row 0, columns 2..9, and read as held-down keys.
  assign w_dip_sel = 3'(r_col - 4'd2);
  assign w_dip = (PA_IN[6:4] == 3'd0) && (r_col >= 4'd2) && (r_col <= 4'd9) &&
                 (int'(r_col) < NUM_COLS) && DIP_LINKS[w_dip_sel];
  assign PA7      = nKBEN & (w_rows[PA_IN[6:4]] | w_dip);
  assign CA2      = r_ca2;
  assign SCAN_COL = r_col;
endmodule

// File: tb/tb_bbc_keyboard_scan.sv
// tb_bbc_keyboard_scan: randomized + directed bench against a key-array reference model.
module tb_bbc_keyboard_scan;
  localparam logic [7:0] DIP = 8'h05;
  logic clk = 1'b0;
  logic nRESET, nKBEN, KEY_VALID, KEY_DOWN, KEY_CLEAR;
  logic [6:0] PA_IN;
  logic [2:0] KEY_ROW;
  logic [3:0] KEY_COL;
  logic CA2, PA7;
  logic [3:0] SCAN_COL;
  int checks = 0, errors = 0;
  bit keys [8][10];
  int m_col;
  bit m_ca2;
  bbc_keyboard_scan #(.NUM_COLS(10), .DIP_LINKS(DIP)) dut (
    .PHI_2(clk), .nRESET(nRESET), .nKBEN(nKBEN), .PA_IN(PA_IN),
    .KEY_VALID(KEY_VALID), .KEY_DOWN(KEY_DOWN), .KEY_ROW(KEY_ROW), .KEY_COL(KEY_COL),
    .KEY_CLEAR(KEY_CLEAR), .CA2(CA2), .PA7(PA7), .SCAN_COL(SCAN_COL)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit sense(input int row, input int col);
    bit s;
    if (col >= 10) return 1'b0;
    s = keys[row][col];
    if (row == 0 && col >= 2) s = s | DIP[col-2];
    return s;
  endfunction
  // Reference: CA2 samples the column being scanned before this edge's key update.
  always @(posedge clk or negedge nRESET) begin : model
    bit irq;
    if (!nRESET) begin
      foreach (keys[r, c]) keys[r][c] = 1'b0;
      m_col = 0;
      m_ca2 = 1'b0;
    end else begin
      irq = 1'b0;
      for (int r = 1; r < 8; r++) if (m_col < 10 && keys[r][m_col]) irq = 1'b1;
      m_ca2 = irq;
      if (KEY_CLEAR) foreach (keys[r, c]) keys[r][c] = 1'b0;
      else if (KEY_VALID && KEY_COL < 10) keys[KEY_ROW][KEY_COL] = KEY_DOWN;
      m_col = nKBEN ? int'(PA_IN[3:0]) : (m_col + 1) % 16;
    end
  end
  always @(negedge clk) begin
    check("m_ca2", 8'(CA2), 8'(m_ca2));
    check("m_col", 8'(SCAN_COL), 8'(m_col));
    check("m_pa7", 8'(PA7), 8'(nKBEN && sense(int'(PA_IN[6:4]), m_col)));
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic key(input int r, input int c, input bit d);
    KEY_VALID = 1'b1; KEY_ROW = 3'(r); KEY_COL = 4'(c); KEY_DOWN = d;
    tick();
    KEY_VALID = 1'b0;
  endtask
  task automatic count_ca2(input int n, output int hits, output int bad);
    hits = 0; bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (CA2) begin
        hits++;
        if (SCAN_COL != 4'd6) bad++;
      end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int hits, bad;
    bit seen;
    nRESET = 1'b0; nKBEN = 1'b0; PA_IN = '0; KEY_VALID = 1'b0; KEY_DOWN = 1'b0;
    KEY_ROW = '0; KEY_COL = '0; KEY_CLEAR = 1'b0;
    #12;
    check("t1_rst_ca2", 8'(CA2), 8'd0);
    check("t1_rst_pa7", 8'(PA7), 8'd0);
    check("t1_rst_col", 8'(SCAN_COL), 8'd0);
    tick();
    nRESET = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      check("t1_count", 8'(SCAN_COL), 8'(i % 16));
    end
    key(3, 5, 1'b1);
    tick(); tick();
    count_ca2(32, hits, bad);
    check("t2_hits", 8'(hits), 8'd2);
    check("t2_col", 8'(bad), 8'd0);
    key(3, 5, 1'b0);
    tick(); tick();
    count_ca2(32, hits, bad);
    check("t2_release", 8'(hits), 8'd0);
    key(0, 0, 1'b1);
    count_ca2(32, hits, bad);
    check("t3_shift_irq", 8'(hits), 8'd0);
    nKBEN = 1'b1; PA_IN = 7'h00;
    tick();
    @(negedge clk);
    check("t3_shift_pa7", 8'(PA7), 8'd1);
    key(0, 0, 1'b0);
    PA_IN = 7'h02; tick(); @(negedge clk);
    check("t4_dip_c2", 8'(PA7), 8'd1);
    PA_IN = 7'h03; tick(); @(negedge clk);
    check("t4_dip_c3", 8'(PA7), 8'd0);
    PA_IN = 7'h04; tick(); @(negedge clk);
    check("t4_dip_c4", 8'(PA7), 8'd1);
    key(7, 9, 1'b1);
    PA_IN = {3'd7, 4'd9};
    tick(); @(negedge clk);
    check("t5_pa7", 8'(PA7), 8'd1);
    tick(); @(negedge clk);
    check("t5_ca2", 8'(CA2), 8'd1);
    KEY_CLEAR = 1'b1;
    KEY_VALID = 1'b1; KEY_ROW = 3'd7; KEY_COL = 4'd9; KEY_DOWN = 1'b1;
    tick();
    KEY_CLEAR = 1'b0; KEY_VALID = 1'b0;
    @(negedge clk);
    check("t5_clear", 8'(PA7), 8'd0);
    key(4, 12, 1'b1);
    PA_IN = {3'd5, 4'd2};
    tick(); @(negedge clk);
    check("t6_col12_alias", 8'(PA7), 8'd0);
    nKBEN = 1'b0;
    key(2, 3, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = CA2;
    end
    check("t6_wait_ca2", 8'(seen), 8'd1);
    check("t6_pre_col", 8'(SCAN_COL), 8'd4);
    #1 nRESET = 1'b0;
    #1;
    check("t6_async_col", 8'(SCAN_COL), 8'd0);
    check("t6_async_ca2", 8'(CA2), 8'd0);
    tick();
    nRESET = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) nKBEN = ~nKBEN;
      PA_IN = 7'($urandom);
      KEY_VALID = ($urandom_range(0, 2) == 0);
      KEY_DOWN = ($urandom_range(0, 2) != 0);
      KEY_ROW = 3'($urandom);
      KEY_COL = 4'($urandom_range(0, 15));
      KEY_CLEAR = ($urandom_range(0, 63) == 0);
      tick();
    end
    KEY_VALID = 1'b0; KEY_CLEAR = 1'b0;
    tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
